// File: rtl/shift_issue_pkg.sv
// shift_issue_pkg
//   Shared types and constants for the shift issue buffer.
//   - Operand/index widths used by the entry struct.
//   - Legal shift funct encodings {funct7[5], funct3}.
//   - shift_issue_entry_t : one buffered operation as presented to the shifter.
//   - occ_state_t         : buffer occupancy (EMPTY / ONE / TWO).
package shift_issue_pkg;

    localparam int XLEN_P      = 32;
    localparam int SHAMT_W_P   = 5;
    localparam int RF_ADDR_W_P = 5;

    localparam logic [3:0] FUNCT_SLL = 4'b0001;
    localparam logic [3:0] FUNCT_SRL = 4'b0101;
    localparam logic [3:0] FUNCT_SRA = 4'b1101;

    typedef struct packed {
        logic [3:0]             funct;
        logic [XLEN_P-1:0]      op1;
        logic [XLEN_P-1:0]      op2;
        logic [RF_ADDR_W_P-1:0] rd;
        logic                   illegal;
    } shift_issue_entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_t;

    function automatic logic funct_is_legal(input logic [3:0] f);
        return (f == FUNCT_SLL) || (f == FUNCT_SRL) || (f == FUNCT_SRA);
    endfunction

endpackage

// File: rtl/shift_operand_sel.sv
// shift_operand_sel
//   Combinational operand resolution for one incoming shift operation.
//   Picks op1 / op2 sources (optionally through the writeback bypass),
//   masks op2 down to the shift amount and flags illegal funct codes.
//   Ports:
//     i_funct, i_rs1, i_rs2, i_rs1_data, i_rs2_data, i_imm, i_use_imm, i_rd
//                  : decoded operation fields
//     i_fwd_*      : writeback bypass (only with SHIFT_ISSUE_FWD_EN)
//     o_entry      : resolved entry ready for capture
//   Macro: SHIFT_ISSUE_FWD_EN enables the bypass inputs.
module shift_operand_sel
    import shift_issue_pkg::*;
(
    input  logic [3:0]             i_funct,
    input  logic [RF_ADDR_W_P-1:0] i_rs1,
    input  logic [RF_ADDR_W_P-1:0] i_rs2,
    input  logic [XLEN_P-1:0]      i_rs1_data,
    input  logic [XLEN_P-1:0]      i_rs2_data,
    input  logic [XLEN_P-1:0]      i_imm,
    input  logic                   i_use_imm,
    input  logic [RF_ADDR_W_P-1:0] i_rd,
`ifdef SHIFT_ISSUE_FWD_EN
    input  logic                   i_fwd_valid,
    input  logic [RF_ADDR_W_P-1:0] i_fwd_rd,
    input  logic [XLEN_P-1:0]      i_fwd_data,
`endif
    output shift_issue_entry_t     o_entry
);

    logic [XLEN_P-1:0] w_op1;
    logic [XLEN_P-1:0] w_src;
    logic              w_legal;

    always_comb begin
        w_op1 = i_rs1_data;
        w_src = i_use_imm ? i_imm : i_rs2_data;
`ifdef SHIFT_ISSUE_FWD_EN
        // x0 never forwards; immediates are never overridden by the bypass.
        if (i_fwd_valid && (i_fwd_rd == i_rs1) && (i_rs1 != '0))
            w_op1 = i_fwd_data;
        if (!i_use_imm && i_fwd_valid && (i_fwd_rd == i_rs2) && (i_rs2 != '0))
            w_src = i_fwd_data;
`endif
    end

    assign w_legal = funct_is_legal(i_funct);

    always_comb begin
        o_entry.funct   = i_funct;
        o_entry.op1     = w_op1;
        // Illegal ops carry a zero shift amount so the shifter output is benign.
        o_entry.op2     = w_legal ? {{(XLEN_P-SHAMT_W_P){1'b0}}, w_src[SHAMT_W_P-1:0]} : '0;
        o_entry.rd      = i_rd;
        o_entry.illegal = !w_legal;
    end

    // Upper source bits are discarded by the shamt mask.
    logic w_unused_src;
    assign w_unused_src = ^w_src[XLEN_P-1:SHAMT_W_P];
`ifndef SHIFT_ISSUE_FWD_EN
    // Register indices only matter for bypass matching.
    logic w_unused_idx;
    assign w_unused_idx = ^{i_rs1, i_rs2};
`endif

endmodule

// File: rtl/shift_issue.sv
// shift_issue
//   Execute-stage issue buffer in front of the combinational shifter.
//   2-entry skid buffer (head + skid) so in_ready_o is a pure flop and
//   never depends on out_ready_i in the same cycle.
//   Ports:
//     clk_i, rst_i (sync, active high), flush_i
//     in_*         : decode handshake and operation fields
//     fwd_*        : writeback bypass (only with SHIFT_ISSUE_FWD_EN)
//     out_valid_o / out_ready_i : shifter handshake
//     funct_o, op1_o, op2_o, rd_o, illegal_o : registered head entry
//   Macro: SHIFT_ISSUE_FWD_EN adds the fwd_* ports and capture-time bypass.
module shift_issue
    import shift_issue_pkg::*;
#(
    parameter int XLEN      = XLEN_P,
    parameter int SHAMT_W   = SHAMT_W_P,
    parameter int RF_ADDR_W = RF_ADDR_W_P
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [3:0]           in_funct_i,
    input  logic [RF_ADDR_W-1:0] in_rs1_i,
    input  logic [RF_ADDR_W-1:0] in_rs2_i,
    input  logic [XLEN-1:0]      in_rs1_data_i,
    input  logic [XLEN-1:0]      in_rs2_data_i,
    input  logic [XLEN-1:0]      in_imm_i,
    input  logic                 in_use_imm_i,
    input  logic [RF_ADDR_W-1:0] in_rd_i,
`ifdef SHIFT_ISSUE_FWD_EN
    input  logic                 fwd_valid_i,
    input  logic [RF_ADDR_W-1:0] fwd_rd_i,
    input  logic [XLEN-1:0]      fwd_data_i,
`endif
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [3:0]           funct_o,
    output logic [XLEN-1:0]      op1_o,
    output logic [XLEN-1:0]      op2_o,
    output logic [RF_ADDR_W-1:0] rd_o,
    output logic                 illegal_o
);

    occ_state_t         r_state, w_state_nxt;
    shift_issue_entry_t r_head, r_skid, w_entry;
    logic               r_ready;
    logic               w_valid, w_accept, w_pop;
    logic               w_head_new, w_skid_new, w_head_from_skid;

    shift_operand_sel u_sel (
        .i_funct    (in_funct_i),
        .i_rs1      (in_rs1_i),
        .i_rs2      (in_rs2_i),
        .i_rs1_data (in_rs1_data_i),
        .i_rs2_data (in_rs2_data_i),
        .i_imm      (in_imm_i),
        .i_use_imm  (in_use_imm_i),
        .i_rd       (in_rd_i),
`ifdef SHIFT_ISSUE_FWD_EN
        .i_fwd_valid(fwd_valid_i),
        .i_fwd_rd   (fwd_rd_i),
        .i_fwd_data (fwd_data_i),
`endif
        .o_entry    (w_entry)
    );

    assign w_accept = in_valid_i & r_ready;
    assign w_pop    = w_valid & out_ready_i;

    // State register; ready is registered from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= EMPTY;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt != TWO);
        end
    end

    // Next-state logic; flush wins over any accept/pop in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY:   if (w_accept) w_state_nxt = ONE;
                ONE: begin
                    if (w_accept && !w_pop)      w_state_nxt = TWO;
                    else if (w_pop && !w_accept) w_state_nxt = EMPTY;
                end
                TWO:     if (w_pop) w_state_nxt = ONE;
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    // Output / datapath-control logic.
    always_comb begin
        w_valid          = (r_state != EMPTY);
        // New entry goes to the head when the head slot is free or being popped.
        w_head_new       = !flush_i && w_accept &&
                           ((r_state == EMPTY) || ((r_state == ONE) && w_pop));
        w_skid_new       = !flush_i && w_accept && (r_state == ONE) && !w_pop;
        w_head_from_skid = !flush_i && w_pop && (r_state == TWO);
    end

    // Head only changes when empty or popped, so outputs hold under stall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (w_head_new)            r_head <= w_entry;
            else if (w_head_from_skid) r_head <= r_skid;
            if (w_skid_new)            r_skid <= w_entry;
        end
    end

    assign in_ready_o  = r_ready;
    assign out_valid_o = w_valid;
    assign funct_o     = r_head.funct;
    assign op1_o       = r_head.op1;
    assign op2_o       = r_head.op2;
    assign rd_o        = r_head.rd;
    assign illegal_o   = r_head.illegal;

endmodule

// File: tb/tb_shift_issue.sv
module tb_shift_issue;

    typedef struct {
        logic [3:0]  funct;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        illegal;
    } exp_t;

`ifdef SHIFT_ISSUE_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, in_use_imm, out_valid, out_ready, illegal;
    logic [3:0]  in_funct, funct;
    logic [4:0]  in_rs1, in_rs2, in_rd, rd, fwd_rd;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm, op1, op2, fwd_data;
    logic        fwd_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_issue dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_funct_i   (in_funct),
        .in_rs1_i     (in_rs1),
        .in_rs2_i     (in_rs2),
        .in_rs1_data_i(in_rs1_data),
        .in_rs2_data_i(in_rs2_data),
        .in_imm_i     (in_imm),
        .in_use_imm_i (in_use_imm),
        .in_rd_i      (in_rd),
`ifdef SHIFT_ISSUE_FWD_EN
        .fwd_valid_i  (fwd_valid),
        .fwd_rd_i     (fwd_rd),
        .fwd_data_i   (fwd_data),
`endif
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .funct_o      (funct),
        .op1_o        (op1),
        .op2_o        (op2),
        .rd_o         (rd),
        .illegal_o    (illegal)
    );

    // Reference: what the shifter should see for an operation captured now.
    function automatic exp_t model(input logic [3:0] f, input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                                   input logic ui, input logic [4:0] rdi, input logic fv,
                                   input logic [4:0] frd, input logic [31:0] fd);
        exp_t e;
        logic [31:0] src;
        e.op1 = d1;
        src   = ui ? imm : d2;
        if (FWD_EN && fv && frd == rs1 && rs1 != 0) e.op1 = fd;
        if (FWD_EN && fv && !ui && frd == rs2 && rs2 != 0) src = fd;
        e.funct   = f;
        e.rd      = rdi;
        e.illegal = !(f == 4'd1 || f == 4'd5 || f == 4'd13);
        e.op2     = e.illegal ? 32'd0 : (src % 32);
        return e;
    endfunction

    task automatic idle();
        rst = 0; flush = 0; in_valid = 0; out_ready = 0;
        in_funct = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_use_imm = 0;
        in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
        fwd_valid = 0; fwd_rd = 0; fwd_data = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic drive_op(input logic [3:0] f, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [31:0] imm, input logic ui, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [4:0] rdi);
        in_valid = 1; in_funct = f; in_rs1_data = d1; in_rs2_data = d2; in_imm = imm;
        in_use_imm = ui; in_rs1 = rs1; in_rs2 = rs2; in_rd = rdi;
    endtask

    task automatic test_reset();
        do_reset();
        drive_op(4'b0101, 32'h1234_5678, 32'h3, 0, 0, 1, 2, 5'd9);
        @(negedge clk);
        rst = 1;   // mid-operation reset with a live input
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
        checks++;
        if (funct !== 4'd0 || op1 !== 32'd0 || op2 !== 32'd0 || rd !== 5'd0) begin
            failures++;
            $display("FAIL reset_data got funct=%h op1=%h op2=%h rd=%h exp all 0", funct, op1, op2, rd);
        end
        rst = 0; in_valid = 0;
    endtask

    task automatic test_sll();
        do_reset();
        drive_op(4'b0001, 32'h0000_00F0, 32'h0000_0024, 32'hFFFF_FFFF, 0, 1, 2, 5'd7);
        @(negedge clk);
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sll_valid got=%b exp=1", out_valid); end
        checks++; if (op2 !== 32'h4) begin failures++; $display("FAIL sll_op2 got=%h exp=00000004", op2); end
        checks++; if (op1 !== 32'hF0 || illegal !== 1'b0 || rd !== 5'd7) begin
            failures++; $display("FAIL sll_fields got op1=%h ill=%b rd=%0d exp op1=000000f0 ill=0 rd=7", op1, illegal, rd);
        end
        out_ready = 1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sll_pop got=%b exp=0", out_valid); end
        out_ready = 0;
    endtask

    task automatic test_sra_imm();
        do_reset();
        drive_op(4'b1101, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 1, 3, 4, 5'd11);
        @(negedge clk);
        in_valid = 0;
        checks++; if (op2 !== 32'h1F) begin failures++; $display("FAIL sra_op2 got=%h exp=0000001f", op2); end
        checks++; if (funct !== 4'b1101) begin failures++; $display("FAIL sra_funct got=%b exp=1101", funct); end
    endtask

    task automatic test_illegal();
        do_reset();
        drive_op(4'b0011, 32'h55, 32'h1F, 0, 0, 1, 2, 5'd3);
        @(negedge clk);
        in_valid = 0;
        checks++; if (illegal !== 1'b1 || op2 !== 32'd0) begin
            failures++; $display("FAIL illegal_entry got ill=%b op2=%h exp ill=1 op2=0", illegal, op2);
        end
        out_ready = 1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL illegal_pop got=%b exp=0", out_valid); end
        out_ready = 0;
    endtask

    task automatic test_back_to_back();
        logic [4:0] got_rd[3];
        int got = 0;
        bit pend = 0;
        do_reset();
        out_ready = 0;
        drive_op(4'b0001, 32'hA, 32'h1, 0, 0, 1, 2, 5'd1);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_one got=%b exp=1", in_ready); end
        drive_op(4'b0101, 32'hB, 32'h2, 0, 0, 1, 2, 5'd2);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_two got=%b exp=0", in_ready); end
        drive_op(4'b1101, 32'hC, 32'h3, 0, 0, 1, 2, 5'd3);
        @(negedge clk);
        checks++; if (rd !== 5'd1 || in_ready !== 1'b0) begin
            failures++; $display("FAIL bp_stall got rd=%0d rdy=%b exp rd=1 rdy=0", rd, in_ready);
        end
        out_ready = 1;
        for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
            if (pend) in_valid = 0;
            if (in_valid && in_ready) pend = 1;
            if (out_valid) begin got_rd[got] = rd; got++; end
            @(negedge clk);
        end
        in_valid = 0;
        checks++; if (got != 3) begin failures++; $display("FAIL bp_count got=%0d exp=3", got); end
        else begin
            checks++;
            if (got_rd[0] !== 5'd1 || got_rd[1] !== 5'd2 || got_rd[2] !== 5'd3) begin
                failures++; $display("FAIL bp_order got=%0d,%0d,%0d exp=1,2,3", got_rd[0], got_rd[1], got_rd[2]);
            end
        end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_nodup got=%b exp=0", out_valid); end
        out_ready = 0;
    endtask

    task automatic test_flush();
        int seen = 0;
        do_reset();
        drive_op(4'b0001, 32'h1, 32'h1, 0, 0, 1, 2, 5'd4);
        @(negedge clk);
        drive_op(4'b0001, 32'h2, 32'h2, 0, 0, 1, 2, 5'd5);
        @(negedge clk);
        drive_op(4'b0101, 32'h9, 32'h9, 0, 0, 1, 2, 5'd9);
        flush = 1;
        @(negedge clk);
        flush = 0; in_valid = 0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL flush_state got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
        end
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL flush_ghost got=%0d exp=0", seen); end
        out_ready = 0;
    endtask

`ifdef SHIFT_ISSUE_FWD_EN
    task automatic test_fwd();
        do_reset();
        drive_op(4'b0001, 32'h0000_1111, 32'h1, 0, 0, 5'd5, 5'd6, 5'd1);
        fwd_valid = 1; fwd_rd = 5'd5; fwd_data = 32'hDEAD_BEEF;
        @(negedge clk);
        in_valid = 0; fwd_valid = 0; out_ready = 1;
        checks++; if (op1 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL fwd_hit got=%h exp=deadbeef", op1); end
        @(negedge clk);
        out_ready = 0;
        drive_op(4'b0001, 32'h0000_2222, 32'h1, 0, 0, 5'd0, 5'd6, 5'd2);
        fwd_valid = 1; fwd_rd = 5'd0; fwd_data = 32'hDEAD_BEEF;
        @(negedge clk);
        in_valid = 0; fwd_valid = 0;
        checks++; if (op1 !== 32'h0000_2222) begin failures++; $display("FAIL fwd_x0 got=%h exp=00002222", op1); end
    endtask
`endif

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        bit   exp_valid, exp_ready, acc, pop;
        logic [3:0] fsel[4];
        fsel[0] = 4'd1; fsel[1] = 4'd5; fsel[2] = 4'd13; fsel[3] = 4'd0;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            exp_valid = (q.size() != 0);
            exp_ready = (q.size() < 2);
            checks++; if (out_valid !== exp_valid) begin failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_valid); end
            checks++; if (in_ready !== exp_ready) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ready); end
            if (exp_valid) begin
                checks++;
                if (funct !== q[0].funct || op1 !== q[0].op1 || op2 !== q[0].op2 ||
                    rd !== q[0].rd || illegal !== q[0].illegal) begin
                    failures++;
                    $display("FAIL rand_data cyc=%0d got f=%h op1=%h op2=%h rd=%0d ill=%b exp f=%h op1=%h op2=%h rd=%0d ill=%b",
                             cyc, funct, op1, op2, rd, illegal, q[0].funct, q[0].op1, q[0].op2, q[0].rd, q[0].illegal);
                end
            end
            rst         = ($urandom_range(0, 99) == 0);
            flush       = ($urandom_range(0, 24) == 0);
            in_valid    = ($urandom_range(0, 2) != 0);
            out_ready   = $urandom_range(0, 1);
            in_funct    = ($urandom_range(0, 4) == 0) ? 4'($urandom) : fsel[$urandom_range(0, 2)];
            in_rs1      = 5'($urandom_range(0, 7));
            in_rs2      = 5'($urandom_range(0, 7));
            in_rd       = 5'($urandom);
            in_rs1_data = $urandom;
            in_rs2_data = $urandom;
            in_imm      = $urandom;
            in_use_imm  = $urandom_range(0, 1);
            fwd_valid   = $urandom_range(0, 1);
            fwd_rd      = 5'($urandom_range(0, 7));
            fwd_data    = $urandom;
            acc = in_valid && exp_ready;
            pop = exp_valid && out_ready;
            e = model(in_funct, in_rs1, in_rs2, in_rs1_data, in_rs2_data, in_imm, in_use_imm,
                      in_rd, fwd_valid, fwd_rd, fwd_data);
            @(posedge clk);
            if (rst || flush) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(e);
            end
            @(negedge clk);
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        test_reset();
        test_sll();
        test_sra_imm();
        test_illegal();
        test_back_to_back();
        test_flush();
`ifdef SHIFT_ISSUE_FWD_EN
        test_fwd();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
